// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one 16-bit address / 8-bit data system bus between two
// request/finish masters. One-cycle requests are latched per master, granted
// round-robin, and issued one at a time. A watchdog aborts transactions the
// slave never finishes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_Idle  | no transaction in flight; grant a pending request
// S_Issue | bus_Cmd pulse for the granted request
// S_Wait  | waiting for bus_Finish or the watchdog to expire
module bus_arbiter #(
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [7:0]  ABORT_DATA = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_Cmd,
  input  logic        m0_RW,
  input  logic [15:0] m0_Addr,
  input  logic [7:0]  m0_WData,
  output logic [7:0]  m0_RData,
  output logic        m0_Finish,
  input  logic        m1_Cmd,
  input  logic        m1_RW,
  input  logic [15:0] m1_Addr,
  input  logic [7:0]  m1_WData,
  output logic [7:0]  m1_RData,
  output logic        m1_Finish,
  output logic [15:0] bus_Addr,
  output logic [7:0]  bus_WData,
  input  logic [7:0]  bus_RData,
  output logic        bus_Cmd,
  output logic        bus_RW,
  input  logic        bus_Finish,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_Idle  = 2'd0,
    S_Issue = 2'd1,
    S_Wait  = 2'd2
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic [1:0]  pend_q, pend_d;
  logic [1:0]  req_rw_q;
  logic [15:0] req_addr_q [2];
  logic [7:0]  req_wdata_q [2];
  logic [1:0]  cmd_w, rw_w;
  logic [15:0] addr_w [2];
  logic [7:0]  wdata_w [2];
  logic [1:0]  capture_d, clr_d;
  logic        gnt_q, gnt_d, last_grant_q;
  logic [15:0] cnt_q;
  logic        cnt_hit, done_d;
  logic [1:0]  fin_q;
  logic [7:0]  rdata_q [2];
  logic        bus_cmd_q, bus_rw_q, timeout_err_q;
  logic [15:0] bus_addr_q;
  logic [7:0]  bus_wdata_q;

  assign cmd_w      = {m1_Cmd, m0_Cmd};
  assign rw_w       = {m1_RW, m0_RW};
  assign addr_w[0]  = m0_Addr;
  assign addr_w[1]  = m1_Addr;
  assign wdata_w[0] = m0_WData;
  assign wdata_w[1] = m1_WData;

  assign m0_RData    = rdata_q[0];
  assign m1_RData    = rdata_q[1];
  assign m0_Finish   = fin_q[0];
  assign m1_Finish   = fin_q[1];
  assign bus_Addr    = bus_addr_q;
  assign bus_WData   = bus_wdata_q;
  assign bus_Cmd     = bus_cmd_q;
  assign bus_RW      = bus_rw_q;
  assign timeout_err = timeout_err_q;

  // Completion detect, pending-flag next state (a new request beats the
  // completion clear) and round-robin grant choice.
  always_comb begin
    cnt_hit   = (cnt_q == CNT_LAST);
    done_d    = (state_q == S_Wait) && (bus_Finish || cnt_hit);
    clr_d     = 2'b00;
    if (done_d) clr_d[gnt_q] = 1'b1;
    capture_d = cmd_w & (~pend_q | clr_d);
    pend_d    = (pend_q & ~clr_d) | capture_d;
    gnt_d     = (&pend_q) ? ~last_grant_q : ~pend_q[0];
  end

  // Per-master request latches and pending flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q   <= 2'b00;
      req_rw_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        req_addr_q[i]  <= 16'h0000;
        req_wdata_q[i] <= 8'h00;
      end
    end else begin
      pend_q <= pend_d;
      for (int i = 0; i < 2; i++) begin
        if (capture_d[i]) begin
          req_rw_q[i]    <= rw_w[i];
          req_addr_q[i]  <= addr_w[i];
          req_wdata_q[i] <= wdata_w[i];
        end
      end
    end
  end

  // Transaction FSM with registered bus and master-side outputs. S_Idle waits
  // out the Finish pulse before granting again, so a queued request that was
  // captured alongside the completion is still arbitrated fairly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_Idle;
      gnt_q         <= 1'b0;
      last_grant_q  <= 1'b1;
      cnt_q         <= 16'h0000;
      fin_q         <= 2'b00;
      rdata_q[0]    <= 8'h00;
      rdata_q[1]    <= 8'h00;
      bus_cmd_q     <= 1'b0;
      bus_rw_q      <= 1'b0;
      bus_addr_q    <= 16'h0000;
      bus_wdata_q   <= 8'h00;
      timeout_err_q <= 1'b0;
    end else begin
      bus_cmd_q <= 1'b0;
      fin_q     <= 2'b00;
      case (state_q)
        S_Idle: begin
          if ((pend_q != 2'b00) && (fin_q == 2'b00)) begin
            gnt_q       <= gnt_d;
            bus_addr_q  <= req_addr_q[gnt_d];
            bus_wdata_q <= req_wdata_q[gnt_d];
            bus_rw_q    <= req_rw_q[gnt_d];
            bus_cmd_q   <= 1'b1;
            state_q     <= S_Issue;
          end
        end
        S_Issue: begin
          cnt_q   <= 16'h0000;
          state_q <= S_Wait;
        end
        S_Wait: begin
          if (bus_Finish) begin
            if (!req_rw_q[gnt_q]) rdata_q[gnt_q] <= bus_RData;
            fin_q[gnt_q] <= 1'b1;
            last_grant_q <= gnt_q;
            state_q      <= S_Idle;
          end else if (cnt_hit) begin
            if (!req_rw_q[gnt_q]) rdata_q[gnt_q] <= ABORT_DATA;
            fin_q[gnt_q]  <= 1'b1;
            last_grant_q  <= gnt_q;
            timeout_err_q <= 1'b1;
            state_q       <= S_Idle;
          end else begin
            cnt_q <= cnt_q + 16'h0001;
          end
        end
        default: state_q <= S_Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios with literal expectations, then random
// traffic, all checked each cycle against a timestamp-based transaction model.
module tb_bus_arbiter;
  localparam int unsigned TO    = 8;
  localparam logic [7:0]  ABORT = 8'hFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        m0_Cmd, m0_RW, m1_Cmd, m1_RW;
  logic [15:0] m0_Addr, m1_Addr;
  logic [7:0]  m0_WData, m1_WData, m0_RData, m1_RData;
  logic        m0_Finish, m1_Finish;
  logic [15:0] bus_Addr;
  logic [7:0]  bus_WData, bus_RData;
  logic        bus_Cmd, bus_RW, bus_Finish, timeout_err;

  bus_arbiter #(.TIMEOUT(TO), .ABORT_DATA(ABORT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_Cmd(m0_Cmd), .m0_RW(m0_RW), .m0_Addr(m0_Addr), .m0_WData(m0_WData),
    .m0_RData(m0_RData), .m0_Finish(m0_Finish),
    .m1_Cmd(m1_Cmd), .m1_RW(m1_RW), .m1_Addr(m1_Addr), .m1_WData(m1_WData),
    .m1_RData(m1_RData), .m1_Finish(m1_Finish),
    .bus_Addr(bus_Addr), .bus_WData(bus_WData), .bus_RData(bus_RData),
    .bus_Cmd(bus_Cmd), .bus_RW(bus_RW), .bus_Finish(bus_Finish),
    .timeout_err(timeout_err)
  );

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  // ---------------- transaction-level reference model ----------------
  int          cyc = 0;
  bit          mp_pend [2];
  bit          mp_rw [2];
  logic [15:0] mp_addr [2];
  logic [7:0]  mp_wd [2];
  bit          busy;
  int          owner, t_grant, grant_ok, last;
  logic        e_cmd, e_rw, e_err;
  logic [15:0] e_addr;
  logic [7:0]  e_wd;
  logic        e_fin [2];
  logic [7:0]  e_rd [2];

  always @(posedge clk) begin : model
    bit          cmd [2];
    bit          rw [2];
    logic [15:0] ad [2];
    logic [7:0]  wd [2];
    int          k;
    cmd[0] = m0_Cmd; rw[0] = m0_RW; ad[0] = m0_Addr; wd[0] = m0_WData;
    cmd[1] = m1_Cmd; rw[1] = m1_RW; ad[1] = m1_Addr; wd[1] = m1_WData;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mp_pend[i] = 0; mp_rw[i] = 0; mp_addr[i] = '0; mp_wd[i] = '0;
        e_fin[i] = 0; e_rd[i] = '0;
      end
      busy = 0; last = 1; grant_ok = 0; owner = 0; t_grant = 0;
      e_cmd = 0; e_rw = 0; e_addr = '0; e_wd = '0; e_err = 0;
    end else begin
      e_cmd = 0; e_fin[0] = 0; e_fin[1] = 0;
      if (busy) begin
        // Wait cycles start two cycles after the grant; cycle k = TO-1 aborts.
        if (cyc >= t_grant + 2) begin
          k = cyc - t_grant - 2;
          if (bus_Finish || k == int'(TO) - 1) begin
            if (!mp_rw[owner]) e_rd[owner] = bus_Finish ? bus_RData : ABORT;
            if (!bus_Finish) e_err = 1;
            e_fin[owner] = 1;
            mp_pend[owner] = 0;
            last = owner;
            busy = 0;
            grant_ok = cyc + 2;
          end
        end
      end else if (cyc >= grant_ok && (mp_pend[0] || mp_pend[1])) begin
        if (mp_pend[0] && mp_pend[1]) owner = 1 - last;
        else owner = mp_pend[0] ? 0 : 1;
        busy = 1; t_grant = cyc; e_cmd = 1;
        e_addr = mp_addr[owner]; e_wd = mp_wd[owner]; e_rw = mp_rw[owner];
      end
      for (int i = 0; i < 2; i++) begin
        if (cmd[i] && !mp_pend[i]) begin
          mp_pend[i] = 1; mp_rw[i] = rw[i]; mp_addr[i] = ad[i]; mp_wd[i] = wd[i];
        end
      end
    end
    cyc++;
  end

  // Every-cycle compare of all DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      tests++;
      if (bus_Cmd !== e_cmd || bus_Addr !== e_addr || bus_WData !== e_wd ||
          bus_RW !== e_rw || m0_Finish !== e_fin[0] || m1_Finish !== e_fin[1] ||
          m0_RData !== e_rd[0] || m1_RData !== e_rd[1] || timeout_err !== e_err) begin
        fails++;
        $display("FAIL model cyc=%0d got cmd=%b addr=%h wd=%h rw=%b fin=%b%b rd0=%h rd1=%h err=%b want cmd=%b addr=%h wd=%h rw=%b fin=%b%b rd0=%h rd1=%h err=%b",
                 cyc, bus_Cmd, bus_Addr, bus_WData, bus_RW, m1_Finish, m0_Finish,
                 m0_RData, m1_RData, timeout_err, e_cmd, e_addr, e_wd, e_rw,
                 e_fin[1], e_fin[0], e_rd[0], e_rd[1], e_err);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    int ncmd, nfin;
    rst_n = 0;
    m0_Cmd = 0; m0_RW = 0; m0_Addr = '0; m0_WData = '0;
    m1_Cmd = 0; m1_RW = 0; m1_Addr = '0; m1_WData = '0;
    bus_RData = '0; bus_Finish = 0;
    nxt(); nxt();
    cmp_en = 1;
    smp();
    chk("rst bus_Cmd", bus_Cmd, 0);
    chk("rst bus_Addr", bus_Addr, 0);
    chk("rst bus_WData", bus_WData, 0);
    chk("rst fin", {m1_Finish, m0_Finish}, 0);
    chk("rst rdata", {m1_RData, m0_RData}, 0);
    chk("rst err", timeout_err, 0);
    nxt(); rst_n = 1;
    nxt();

    // Simultaneous requests after reset: m0 first, m1 issued after m0_Finish.
    for (int i = 0; i <= 11; i++) begin
      m0_Cmd = (i == 0); m1_Cmd = (i == 0);
      if (i == 0) begin
        m0_RW = 1; m0_Addr = 16'h0300; m0_WData = 8'h33;
        m1_RW = 0; m1_Addr = 16'h0301; m1_WData = 8'h00;
      end
      bus_Finish = (i == 4 || i == 9);
      bus_RData = (i == 9) ? 8'hAB : 8'hEE;
      smp();
      case (i)
        2: begin
          chk("t2a m0 bus_Cmd", bus_Cmd, 1); chk("t2a m0 addr", bus_Addr, 16'h0300);
          chk("t2a m0 rw", bus_RW, 1); chk("t2a m0 wdata", bus_WData, 8'h33);
        end
        5: begin
          chk("t2a m0_Finish", m0_Finish, 1); chk("t2a m1_Finish low", m1_Finish, 0);
          chk("t2a m0_RData write", m0_RData, 0);
        end
        6: chk("t2a gap", bus_Cmd, 0);
        7: begin chk("t2a m1 bus_Cmd", bus_Cmd, 1); chk("t2a m1 addr", bus_Addr, 16'h0301); end
        10: begin chk("t2a m1_Finish", m1_Finish, 1); chk("t2a m1_RData", m1_RData, 8'hAB); end
        default: ;
      endcase
      nxt();
    end

    // Single read from m0.
    for (int i = 0; i <= 8; i++) begin
      m0_Cmd = (i == 0);
      if (i == 0) begin m0_RW = 0; m0_Addr = 16'h2002; end
      bus_Finish = (i == 5);
      bus_RData = (i == 5) ? 8'h5A : 8'h00;
      smp();
      case (i)
        1: chk("t1 no early cmd", bus_Cmd, 0);
        2: begin chk("t1 bus_Cmd", bus_Cmd, 1); chk("t1 addr", bus_Addr, 16'h2002); chk("t1 rw", bus_RW, 0); end
        3: chk("t1 cmd one cycle", bus_Cmd, 0);
        5: chk("t1 fin early", m0_Finish, 0);
        6: begin
          chk("t1 m0_Finish", m0_Finish, 1); chk("t1 m0_RData", m0_RData, 8'h5A);
          chk("t1 m1_Finish", m1_Finish, 0); chk("t1 m1_RData kept", m1_RData, 8'hAB);
        end
        7: begin chk("t1 fin pulse", m0_Finish, 0); chk("t1 rdata held", m0_RData, 8'h5A); end
        default: ;
      endcase
      nxt();
    end

    // Back-to-back m0: capture during completion, drop while pending.
    ncmd = 0;
    for (int i = 0; i <= 16; i++) begin
      m0_Cmd = (i == 0 || i == 4 || i == 5);
      if (i == 0) begin m0_RW = 0; m0_Addr = 16'h1000; end
      if (i == 4) begin m0_RW = 1; m0_Addr = 16'h0400; m0_WData = 8'h44; end
      if (i == 5) begin m0_RW = 1; m0_Addr = 16'h0500; m0_WData = 8'h55; end
      bus_Finish = (i == 4 || i == 9);
      bus_RData = (i == 4) ? 8'h11 : 8'h99;
      smp();
      if (i >= 1) ncmd += int'(bus_Cmd);
      case (i)
        5: begin chk("t3 m0_Finish 1", m0_Finish, 1); chk("t3 m0_RData", m0_RData, 8'h11); end
        7: begin
          chk("t3 reissue", bus_Cmd, 1); chk("t3 addr", bus_Addr, 16'h0400);
          chk("t3 wdata", bus_WData, 8'h44); chk("t3 rw", bus_RW, 1);
        end
        10: begin chk("t3 m0_Finish 2", m0_Finish, 1); chk("t3 rdata kept", m0_RData, 8'h11); end
        default: ;
      endcase
      nxt();
    end
    chk("t3 bus_Cmd count", ncmd, 2);

    // Simultaneous again with m0 last served: m1 wins this time.
    for (int i = 0; i <= 11; i++) begin
      m0_Cmd = (i == 0); m1_Cmd = (i == 0);
      if (i == 0) begin
        m0_RW = 0; m0_Addr = 16'h0600; m1_RW = 0; m1_Addr = 16'h0601;
      end
      bus_Finish = (i == 4 || i == 9);
      bus_RData = (i == 4) ? 8'h21 : 8'h22;
      smp();
      case (i)
        2: begin chk("t2b m1 first", bus_Cmd, 1); chk("t2b m1 addr", bus_Addr, 16'h0601); end
        5: begin
          chk("t2b m1_Finish", m1_Finish, 1); chk("t2b m1_RData", m1_RData, 8'h21);
          chk("t2b m0 wait", m0_Finish, 0);
        end
        6: chk("t2b F+2 no cmd", bus_Cmd, 0);
        7: begin chk("t2b m0 at F+3", bus_Cmd, 1); chk("t2b m0 addr", bus_Addr, 16'h0600); end
        10: begin chk("t2b m0_Finish", m0_Finish, 1); chk("t2b m0_RData", m0_RData, 8'h22); end
        default: ;
      endcase
      nxt();
    end

    // bus_Finish on the final watchdog cycle: finish wins, no error.
    for (int i = 0; i <= 13; i++) begin
      m0_Cmd = (i == 0);
      if (i == 0) begin m0_RW = 0; m0_Addr = 16'h0700; end
      bus_Finish = (i == 10);
      bus_RData = (i == 10) ? 8'h12 : 8'h00;
      smp();
      case (i)
        10: chk("t5 fin early", m0_Finish, 0);
        11: begin
          chk("t5 m0_Finish", m0_Finish, 1); chk("t5 m0_RData", m0_RData, 8'h12);
          chk("t5 no err", timeout_err, 0);
        end
        12: chk("t5 no err later", timeout_err, 0);
        default: ;
      endcase
      nxt();
    end

    // Timeout on an m1 read, then a normal m0 transaction.
    for (int i = 0; i <= 19; i++) begin
      m0_Cmd = (i == 12); m1_Cmd = (i == 0);
      if (i == 0) begin m1_RW = 0; m1_Addr = 16'h0800; end
      if (i == 12) begin m0_RW = 0; m0_Addr = 16'h0810; end
      bus_Finish = (i == 16);
      bus_RData = (i == 16) ? 8'h34 : 8'h00;
      smp();
      case (i)
        10: begin chk("t4 fin early", m1_Finish, 0); chk("t4 err early", timeout_err, 0); end
        11: begin
          chk("t4 m1_Finish", m1_Finish, 1); chk("t4 abort data", m1_RData, 8'hFF);
          chk("t4 err set", timeout_err, 1);
        end
        14: begin chk("t4 m0 issue", bus_Cmd, 1); chk("t4 m0 addr", bus_Addr, 16'h0810); end
        17: begin
          chk("t4 m0_Finish", m0_Finish, 1); chk("t4 m0_RData", m0_RData, 8'h34);
          chk("t4 err sticky", timeout_err, 1);
        end
        19: chk("t4 err sticky late", timeout_err, 1);
        default: ;
      endcase
      nxt();
    end

    // Reset during S_Wait with m1 pending; late bus_Finish must be ignored.
    ncmd = 0; nfin = 0;
    for (int i = 0; i <= 20; i++) begin
      m0_Cmd = (i == 0); m1_Cmd = (i == 2);
      if (i == 0) begin m0_RW = 0; m0_Addr = 16'h0900; end
      if (i == 2) begin m1_RW = 0; m1_Addr = 16'h0901; end
      rst_n = (i != 4);
      bus_Finish = (i == 5 || i == 7);
      bus_RData = 8'h55;
      smp();
      if (i >= 5) begin
        ncmd += int'(bus_Cmd);
        nfin += int'(m0_Finish) + int'(m1_Finish);
      end
      if (i == 5) begin
        chk("t6 bus_Addr", bus_Addr, 0); chk("t6 bus_WData", bus_WData, 0);
        chk("t6 bus_RW", bus_RW, 0); chk("t6 rdata", {m1_RData, m0_RData}, 0);
        chk("t6 err cleared", timeout_err, 0);
      end
      nxt();
    end
    chk("t6 no finish", nfin, 0);
    chk("t6 no bus_Cmd", ncmd, 0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      m0_Cmd = ($urandom_range(0, 5) == 0);
      m1_Cmd = ($urandom_range(0, 5) == 0);
      m0_RW = 1'($urandom_range(0, 1)); m1_RW = 1'($urandom_range(0, 1));
      m0_Addr = 16'($urandom); m1_Addr = 16'($urandom);
      m0_WData = 8'($urandom); m1_WData = 8'($urandom);
      bus_Finish = ($urandom_range(0, 4) == 0);
      bus_RData = 8'($urandom);
      nxt();
    end
    rst_n = 1; m0_Cmd = 0; m1_Cmd = 0;
    for (int i = 0; i < 40; i++) begin
      bus_Finish = ($urandom_range(0, 3) == 0);
      bus_RData = 8'($urandom);
      nxt();
    end
    smp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single 16-bit address / 8-bit data system bus between two masters.
- Master 0 is the UART debug command path (wr_bus_data style: one-cycle Cmd pulse, waits for Finish). Master 1 is the secondary requester (CPU/DMA side), using the identical protocol.
- Latches one-cycle requests, arbitrates round-robin, issues one bus transaction at a time, and returns read data plus a Finish pulse to the owning master.
- A watchdog aborts transactions the slave never finishes.

Parameters:
TIMEOUT, 255, cycles in S_Wait without bus_Finish before abort (1..65535)
ABORT_DATA, 8'hFF, read data returned on a timed-out transaction

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
m0_Cmd  in  1  master 0 request pulse (1 cycle)
m0_RW  in  1  master 0 direction, 1=write 0=read, valid with m0_Cmd
m0_Addr  in  16  master 0 address, valid with m0_Cmd
m0_WData  in  8  master 0 write data, valid with m0_Cmd
m0_RData  out  8  master 0 read data, valid when m0_Finish=1 and held after
m0_Finish  out  1  master 0 completion pulse (1 cycle)
m1_Cmd, m1_RW, m1_Addr, m1_WData, m1_RData, m1_Finish  same as m0 for master 1
bus_Addr  out  16  system bus address
bus_WData  out  8  system bus write data
bus_RData  in  8  system bus read data, valid with bus_Finish
bus_Cmd  out  1  system bus start pulse (1 cycle)
bus_RW  out  1  system bus direction
bus_Finish  in  1  slave completion
timeout_err  out  1  sticky flag, set on any abort

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values:
  - bus_Cmd=0, bus_RW=0, bus_Addr=0, bus_WData=0.
  - mX_Finish=0, mX_RData=0, timeout_err=0.
  - Both pending flags=0, state=S_Idle, counter=0, last_grant=1 (so m0 wins the first tie).
- Request capture:
  - On a cycle with mX_Cmd=1 and pendX=0, latch RW/Addr/WData into master X's request register and set pendX.
  - mX_Cmd while pendX=1 is dropped; the latched request is unchanged.
  - When pendX is being cleared at completion in the same cycle mX_Cmd arrives, the set wins and the new request is captured.
- FSM states: S_Idle, S_Issue, S_Wait.
- S_Idle:
  - No pending request: stay.
  - One pending request: grant it.
  - Both pending: grant the master not equal to last_grant.
  - On grant: drive bus_Addr/bus_WData/bus_RW from the granted latch, record grant, go to S_Issue.
- S_Issue:
  - bus_Cmd=1 for exactly this one cycle.
  - Clear counter, go to S_Wait.
- S_Wait:
  - Counter increments each cycle.
  - If bus_Finish=1: if the granted request is a read, register bus_RData into mX_RData. Then pulse mX_Finish the next cycle, clear pendX, set last_grant=X, go to S_Idle.
  - Else if counter == TIMEOUT-1: mX_RData=ABORT_DATA (reads only), pulse mX_Finish, clear pendX, set timeout_err, update last_grant, go to S_Idle.
  - bus_Finish in the same cycle as timeout: Finish wins; no error.
- bus_Addr, bus_WData and bus_RW stay stable from S_Issue through the last S_Wait cycle. They hold their last value in S_Idle.
- bus_Finish outside S_Wait is ignored.
- mX_RData is unchanged on write completions and on the other master's completions.
- Latency:
  - mX_Cmd at cycle N: pending at N+1 (S_Idle grant), bus_Cmd at N+2.
  - bus_Finish at cycle F: mX_Finish at F+1. The next queued grant's bus_Cmd comes at F+3 at the earliest.
- Exactly one outstanding bus transaction at any time. Never both mX_Finish high in the same cycle.
- timeout_err clears only on reset.
- Reset mid-transaction: everything returns to reset values. The in-flight and pending requests are dropped, and no mX_Finish is emitted.
- Counter: 16 bits. Arithmetic never wraps, because the abort fires at TIMEOUT-1.

Test Plan:
1. Single read. m0_Cmd (RW=0, Addr=16'h2002) at cycle 10; slave returns bus_RData=8'h5A with bus_Finish at cycle 15 -> bus_Cmd=1 at cycle 12 only, bus_Addr=16'h2002, m0_Finish=1 at cycle 16, m0_RData=8'h5A; m1 outputs unchanged.
2. Simultaneous requests. m0 writes 8'h33 to 16'h0300 and m1 reads 16'h0301, both with Cmd at the same cycle after reset -> m0 transaction issued first, m1 issued after m0_Finish. Repeat both requests -> m1 is served first this time (round-robin).
3. Back-to-back same master. m0_Cmd in the same cycle that m0_Finish is being generated -> new request captured and issued; a second m0_Cmd while pending -> dropped, with exactly one extra bus_Cmd.
4. Timeout. TIMEOUT=8; slave never asserts bus_Finish on an m1 read -> m1_Finish 8 cycles after S_Wait entry, m1_RData=8'hFF, timeout_err=1 and it stays 1; a subsequent m0 transaction completes normally.
5. Finish on the timeout cycle. bus_Finish=1 exactly at counter TIMEOUT-1 with RData=8'h12 -> m0_RData=8'h12, timeout_err stays 0.
6. Reset mid-transaction. rst_n=0 for one cycle during S_Wait with m1 pending -> all outputs return to reset values, no mX_Finish is ever emitted, and a late bus_Finish is ignored.
